// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor table-update path.
//   - bp_state_e : update controller state encoding (INIT sweep / RUN)
//   - bp_entry_t : one queued update {table index, resolved direction}
//   - BP_IDX_W / BP_FIFO_DEPTH : default geometry, shared with the BHT/PHT
// The entry index field is BP_IDX_W wide; a controller built with a smaller
// IDX_W stores its index zero-extended into this field.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_IDX_W      = 10;
    localparam int BP_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
    } bp_entry_t;

endpackage : bp_pkg

// File: rtl/bp_upd_fifo.sv
// ---------------------------------------------------------------------------
// bp_upd_fifo
// Small in-order synchronous FIFO holding pending predictor-table updates.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            empty the queue next cycle (overrides wr_en/rd_en)
//   wr_en, wr_data   push one entry (caller guarantees !full or rd_en)
//   rd_en            pop the head entry (caller guarantees !empty)
//   rd_data          head entry (valid while !empty)
//   count/full/empty occupancy status
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module bp_upd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is never read before it is
    // written because occupancy is tracked by the reset pointers/count.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);

endmodule : bp_upd_fifo

// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl
// Owns the single write port of the branch predictor tables (BHT/PHT).
// After reset or a software clear it sweeps every index writing a clear;
// otherwise it queues resolved M-stage branches and writes them in order.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   branchM, actual_takeM,
//   pred_takeM, pcM         M-stage resolved branch
//   clr_req                 pulse: re-clear all tables
//   tbl_ready               write port accepts a write this cycle
//   tbl_we/tbl_clr/
//   tbl_waddr/tbl_taken     table write request (held while !tbl_ready)
//   init_busy               clear sweep in progress
//   stall_req               hold the M stage: update cannot be queued
//   fifo_full               update queue full
//   upd_cnt, mispred_cnt    statistics counters
// Optional feature macro: BP_STATS_EN enables the saturating statistics
// counters; without it both counters read 0 and pred_takeM is ignored.
// ---------------------------------------------------------------------------
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W      = BP_IDX_W,      // must not exceed BP_IDX_W
    parameter int FIFO_DEPTH = BP_FIFO_DEPTH,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchM,
    input  logic             actual_takeM,
    input  logic             pred_takeM,
    input  logic [31:0]      pcM,
    input  logic             clr_req,
    input  logic             tbl_ready,
    output logic             tbl_we,
    output logic             tbl_clr,
    output logic [IDX_W-1:0] tbl_waddr,
    output logic             tbl_taken,
    output logic             init_busy,
    output logic             stall_req,
    output logic             fifo_full,
    output logic [CNT_W-1:0] upd_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] addr_q,  addr_d;

    bp_entry_t        enq_entry, head;
    logic             fifo_empty;
    logic             enq, deq, flush;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // A clear issued in RUN discards the queue and any same-cycle branch:
    // those updates refer to table contents about to be wiped.
    assign flush = clr_req && (state_q == ST_RUN);
    assign deq   = (state_q == ST_RUN) && !fifo_empty && tbl_ready;
    assign enq   = branchM && (!fifo_full || deq) && !flush;

    assign stall_req = branchM && fifo_full && !deq;

    assign enq_entry.idx   = BP_IDX_W'(pcM[IDX_W+1:2]);
    assign enq_entry.taken = actual_takeM;

    bp_upd_fifo #(
        .DW    ($bits(bp_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush   (flush),
        .wr_en   (enq),
        .wr_data (enq_entry),
        .rd_en   (deq),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_INIT: begin
                // tbl_we is always high here, so tbl_ready alone marks a transfer.
                if (clr_req) begin
                    addr_d = '0;
                end else if (tbl_ready) begin
                    if (addr_q == '1) begin
                        state_d = ST_RUN;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d = ST_INIT;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        init_busy = (state_q == ST_INIT);
        tbl_we    = init_busy || !fifo_empty;
        tbl_clr   = init_busy;
        tbl_waddr = init_busy ? addr_q : head.idx[IDX_W-1:0];
        tbl_taken = init_busy ? 1'b0   : head.taken;
    end

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] upd_cnt_q,     upd_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        upd_cnt_d     = upd_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (deq && (upd_cnt_q != '1))
            upd_cnt_d = upd_cnt_q + CNT_W'(1);
        if (enq && (pred_takeM != actual_takeM) && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    // Statistics survive a software clear; only reset zeroes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            upd_cnt_q     <= upd_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign upd_cnt     = upd_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign upd_cnt     = '0;
    assign mispred_cnt = '0;
`endif

    // Bits intentionally not consumed: PC bits outside the index, index bits
    // above IDX_W, the prediction (stats build only) and the raw count.
    logic unused_bits;
    assign unused_bits = ^{pcM, pred_takeM, head, fifo_count};

endmodule : bp_update_ctrl

// File: tb/tb_bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_update_ctrl
// Directed bench for bp_update_ctrl with IDX_W=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are compared
// mid-cycle. Counter expectations depend on BP_STATS_EN.
// ---------------------------------------------------------------------------
module tb_bp_update_ctrl;

    localparam int IDX_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             branchM, actual_takeM, pred_takeM;
    logic [31:0]      pcM;
    logic             clr_req, tbl_ready;
    logic             tbl_we, tbl_clr, tbl_taken, init_busy, stall_req, fifo_full;
    logic [IDX_W-1:0] tbl_waddr;
    logic [CNT_W-1:0] upd_cnt, mispred_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    bp_update_ctrl #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .pred_takeM   (pred_takeM),
        .pcM          (pcM),
        .clr_req      (clr_req),
        .tbl_ready    (tbl_ready),
        .tbl_we       (tbl_we),
        .tbl_clr      (tbl_clr),
        .tbl_waddr    (tbl_waddr),
        .tbl_taken    (tbl_taken),
        .init_busy    (init_busy),
        .stall_req    (stall_req),
        .fifo_full    (fifo_full),
        .upd_cnt      (upd_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int idx, input logic tk, input logic pr);
        branchM      = 1'b1;
        pcM          = 32'hABC0_0000 | (32'(idx) << 2);
        actual_takeM = tk;
        pred_takeM   = pr;
    endtask

    int          q_idx [5] = '{3, 5, 9, 9, 11};
    logic        q_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        q_pr  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b0; branchM = 1'b0; actual_takeM = 1'b0; pred_takeM = 1'b0;
        pcM = '0; clr_req = 1'b0; tbl_ready = 1'b1;

        // Reset values
        #2;
        check("rst_full",    32'(fifo_full),   32'd0);
        check("rst_stall",   32'(stall_req),   32'd0);
        check("rst_addr",    32'(tbl_waddr),   32'd0);
        check("rst_upd",     upd_cnt,          32'd0);
        check("rst_mispred", mispred_cnt,      32'd0);
        tick();
        rst = 1'b1;

        // Initial sweep, always ready: 16 clear writes 0..15, then RUN
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("sweep_we_%0d", i),   32'(tbl_we),    32'd1);
            check($sformatf("sweep_clr_%0d", i),  32'(tbl_clr),   32'd1);
            check($sformatf("sweep_addr_%0d", i), 32'(tbl_waddr), 32'(i));
            check($sformatf("sweep_busy_%0d", i), 32'(init_busy), 32'd1);
            tick();
        end
        #1;
        check("run_busy", 32'(init_busy), 32'd0);
        check("run_we",   32'(tbl_we),    32'd0);

        // Single update, no bypass: write appears the cycle after branchM
        branchM = 1'b1; pcM = 32'h0000_0048; actual_takeM = 1'b1; pred_takeM = 1'b1;
        #1;
        check("single_stall",  32'(stall_req), 32'd0);
        check("single_nobyp",  32'(tbl_we),    32'd0);
        tick();
        branchM = 1'b0;
        #1;
        check("single_we",    32'(tbl_we),    32'd1);
        check("single_clr",   32'(tbl_clr),   32'd0);
        check("single_addr",  32'(tbl_waddr), 32'h2);
        check("single_taken", 32'(tbl_taken), 32'd1);
        tick();
        #1;
        check("single_done", 32'(tbl_we), 32'd0);

        // Software clear in RUN, ready toggling 0,1,0,1...: 32-cycle sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tbl_ready = (k % 2 == 1);
            #1;
            check($sformatf("tog_addr_%0d", k), 32'(tbl_waddr), 32'(k / 2));
            check($sformatf("tog_busy_%0d", k), 32'(init_busy), 32'd1);
            tick();
        end
        #1;
        check("tog_run", 32'(init_busy), 32'd0);

        // Five branches while the port is blocked: fill, stall, then drain
        tbl_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            present(q_idx[j], q_tk[j], q_pr[j]);
            #1;
            check($sformatf("fill_stall_%0d", j), 32'(stall_req), 32'd0);
            tick();
        end
        present(q_idx[4], q_tk[4], q_pr[4]);
        #1;
        check("full_flag",   32'(fifo_full), 32'd1);
        check("full_stall",  32'(stall_req), 32'd1);
        check("full_head",   32'(tbl_waddr), 32'd3);
        check("full_htaken", 32'(tbl_taken), 32'd1);
        tick();
        check("held_stall", 32'(stall_req), 32'd1);
        tbl_ready = 1'b1;
        #1;
        check("deq_stall", 32'(stall_req), 32'd0);
        tick();
        branchM = 1'b0;
        #1;
        check("swap_full", 32'(fifo_full), 32'd1);
        for (int j = 1; j < 5; j++) begin
            #1;
            check($sformatf("drain_addr_%0d", j),  32'(tbl_waddr), 32'(q_idx[j]));
            check($sformatf("drain_taken_%0d", j), 32'(tbl_taken), 32'(q_tk[j]));
            check($sformatf("drain_clr_%0d", j),   32'(tbl_clr),   32'd0);
            tick();
        end
        #1;
        check("drain_empty", 32'(tbl_we),    32'd0);
        check("drain_full",  32'(fifo_full), 32'd0);

        // Clear with three queued entries plus a same-cycle branch
        tbl_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            present(j + 1, 1'b1, 1'b1);
            tick();
        end
        present(6, 1'b0, 1'b0);
        clr_req = 1'b1;
        #1;
        check("clr_stall", 32'(stall_req), 32'd0);
        tick();
        branchM = 1'b0; clr_req = 1'b0;
        #1;
        check("clr_busy", 32'(init_busy), 32'd1);
        check("clr_addr", 32'(tbl_waddr), 32'd0);
        check("clr_full", 32'(fifo_full), 32'd0);
        tbl_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("clr_sweep_%0d", i), 32'(tbl_waddr), 32'(i));
            check($sformatf("clr_isclr_%0d", i), 32'(tbl_clr),   32'd1);
            tick();
        end
        #1;
        check("clr_run",      32'(init_busy), 32'd0);
        check("clr_no_stale", 32'(tbl_we),    32'd0);

        // Statistics: 6 updates written, 2 mispredicts accepted
`ifdef BP_STATS_EN
        check("stat_upd",     upd_cnt,     32'd6);
        check("stat_mispred", mispred_cnt, 32'd2);
`else
        check("stat_upd_off",     upd_cnt,     32'd0);
        check("stat_mispred_off", mispred_cnt, 32'd0);
`endif

        // Asynchronous reset in the middle of a sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        check("mid_addr", 32'(tbl_waddr), 32'd2);
        rst = 1'b0;
        #1;
        check("arst_addr",    32'(tbl_waddr),  32'd0);
        check("arst_busy",    32'(init_busy),  32'd1);
        check("arst_upd",     upd_cnt,         32'd0);
        check("arst_mispred", mispred_cnt,     32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("rerun_addr", 32'(tbl_waddr), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_bp_update_ctrl
